// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NumReq valid/ready producers.
// Define FIFO_ARB_BURST_LIMIT_EN to also release a grant after MaxBurst accepted beats.
module fifo_wr_arbiter #(
    parameter int NumReq    = 4,
    parameter int FifoWidth = 16,
    parameter int MaxBurst  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*FifoWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq-1:0]             grant_o,
    output logic [$clog2(NumReq)-1:0]     grant_id_o,
    output logic [FifoWidth-1:0]          fifo_data_o,
    output logic                          fifo_wr_en_o,
    input  logic                          fifo_full_i
);

    localparam int IdW  = $clog2(NumReq);
    localparam int CntW = $clog2(MaxBurst + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]           state_reg;
    logic [IdW-1:0]       rr_ptr_reg;
    logic [IdW-1:0]       owner_reg;
    logic [CntW-1:0]      beat_cnt_reg;

    logic [IdW-1:0]       pick_idx;
    logic                 pick_found;
    logic [IdW-1:0]       cand_idx;
    int                   cand;
    logic [IdW-1:0]       owner_inc;
    logic                 in_burst;
    logic                 accept;
    logic                 limit_hit;
    logic                 release_beat;
    logic [FifoWidth-1:0] data_slice [NumReq];

    assign in_burst = (state_reg == ST_BURST);

    // First valid requester at or after rr_ptr, wrapping modulo NumReq.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_reg;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdW'(cand);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign data_slice[gi]  = req_data_i[gi*FifoWidth +: FifoWidth];
            assign grant_o[gi]     = in_burst && (owner_reg == IdW'(gi));
            assign req_ready_o[gi] = in_burst && (owner_reg == IdW'(gi)) && !fifo_full_i;
        end
    endgenerate

    assign accept       = in_burst && req_valid_i[owner_reg] && !fifo_full_i;
    assign fifo_wr_en_o = accept;
    assign fifo_data_o  = in_burst ? data_slice[owner_reg] : '0;
    assign grant_id_o   = in_burst ? owner_reg : '0;
    assign owner_inc    = (owner_reg == IdW'(NumReq - 1)) ? '0 : owner_reg + 1'b1;

`ifdef FIFO_ARB_BURST_LIMIT_EN
    // This accepted beat brings the count up to MaxBurst.
    assign limit_hit = (beat_cnt_reg == CntW'(MaxBurst - 1));
`else
    assign limit_hit = 1'b0;
`endif

    assign release_beat = accept && (req_last_i[owner_reg] || limit_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner_reg    <= pick_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_BURST;
                    end
                end
                default: begin
                    if (accept && (beat_cnt_reg != {CntW{1'b1}})) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                    if (release_beat) begin
                        state_reg  <= ST_IDLE;
                        rr_ptr_reg <= owner_inc;
                    end
                end
            endcase
        end
    end

endmodule
